atan_share_arbiter: RTL



---
 rtl/atan_share_arbiter_if.sv | 28 ++
 rtl/atan_share_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/atan_share_arbiter_if.sv
// Request/response bundle between requesters and the atan arbiter.
// master: requesters + response sink; slave: the arbiter.
interface atan_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_y;
   logic [NUM_REQ*WIDTH-1:0] req_x;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [ID_W-1:0]          resp_id;
   logic [WIDTH-1:0]         resp_theta;
   logic                     resp_err;

   modport master (
      output req_valid, req_y, req_x, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_theta, resp_err
   );

   modport slave (
      input  req_valid, req_y, req_x, resp_ready,
      output req_ready, resp_valid, resp_id, resp_theta, resp_err
   );
endinterface

// File: rtl/atan_share_arbiter.sv
// Round-robin sharing of one iterative cordic_arctan engine among NUM_REQ
// requesters; ports: clk, rst (sync, high), bus (slave), eng_* engine side,
// busy. Optional watchdog: define ATAN_ARB_TIMEOUT_EN.
module atan_share_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int WIDTH          = 16,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   atan_share_arbiter_if.slave  bus,
   output logic                 eng_valid_in,
   output logic [WIDTH-1:0]     eng_y,
   output logic [WIDTH-1:0]     eng_x,
   input  logic [WIDTH-1:0]     eng_theta,
   input  logic                 eng_valid_out,
   output logic                 eng_rst,
   output logic                 busy
);
   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state;
   state_t             state_n;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    grant;
   logic [ID_W-1:0]    id_q;
   logic [WIDTH-1:0]   theta_q;
   logic               found;
   logic               accept;
   logic               timeout;
   logic               resp_err_w;
   logic [NUM_REQ-1:0] req_ready_w;
   logic               resp_valid_w;
   int                 idx;

   // Scan from the farthest offset down so the nearest valid
   // requester after ptr is the last one written.
   always_comb begin
      grant = ptr;
      found = 1'b0;
      idx   = 0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (bus.req_valid[ID_W'(idx)]) begin
            grant = ID_W'(idx);
            found = 1'b1;
         end
      end
   end

   // A done pulse in IDLE blocks acceptance so an issue never
   // lands while the engine may still be draining.
   assign accept = (state == IDLE) && found && !eng_valid_out;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (accept) state_n = ISSUE;
         ISSUE: state_n = WAIT;
         WAIT:  if (eng_valid_out || timeout) state_n = RESP;
         RESP:  if (bus.resp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      req_ready_w  = '0;
      eng_valid_in = 1'b0;
      resp_valid_w = 1'b0;
      busy         = (state != IDLE);
      unique case (1'b1)
         accept:          req_ready_w  = NUM_REQ'(1) << grant;
         (state == ISSUE): eng_valid_in = 1'b1;
         (state == RESP):  resp_valid_w = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= ID_W'(NUM_REQ - 1);
         id_q    <= '0;
         eng_y   <= '0;
         eng_x   <= '0;
         theta_q <= '0;
      end else begin
         if (accept) begin
            ptr   <= grant;
            id_q  <= grant;
            eng_y <= bus.req_y[int'(grant)*WIDTH +: WIDTH];
            eng_x <= bus.req_x[int'(grant)*WIDTH +: WIDTH];
         end
         if (state == WAIT) begin
            if (eng_valid_out) theta_q <= eng_theta;
            else if (timeout)  theta_q <= '0;
         end
      end
   end

`ifdef ATAN_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             wd_rst;
   logic             err_q;

   // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a done pulse
   // in that same cycle takes precedence.
   assign timeout = (state == WAIT) && !eng_valid_out &&
                    (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         wd_rst <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wd_rst <= timeout;
         if (state == ISSUE)     wd_cnt <= '0;
         else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
         if (state == WAIT) begin
            if (eng_valid_out) err_q <= 1'b0;
            else if (timeout)  err_q <= 1'b1;
         end
      end
   end

   assign eng_rst    = rst | wd_rst;
   assign resp_err_w = err_q;
`else
   assign timeout    = 1'b0;
   assign eng_rst    = rst;
   assign resp_err_w = 1'b0;
`endif

   assign bus.req_ready  = req_ready_w;
   assign bus.resp_valid = resp_valid_w;
   assign bus.resp_id    = id_q;
   assign bus.resp_theta = theta_q;
   assign bus.resp_err   = resp_err_w;
endmodule
